button_event: RTL and testbench

//  Consumes the debounced, clk-synchronous button level from the debounce stage.

---
 rtl/stopwatch_pkg.sv | 16 +
 rtl/button_event.sv | 155 +++++++++++++++
 tb/tb_button_event.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types and helpers: button FSM states and ms-to-cycle conversion.
package stopwatch_pkg;

  typedef enum logic [1:0] {WAIT_LOW, IDLE, PRESSED, LONG_HELD} btn_state_t;

  // Number of clock cycles in a span of milliseconds.
  function automatic int ms_to_cycles(input int clk_freq, input int ms);
    return clk_freq / 1000 * ms;
  endfunction

  // Larger of two integers, used to size shared counters.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event.sv
// Turns a debounced button level into single-cycle press/release/short/long/repeat events.
module button_event
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200,
  parameter bit REPEAT_EN = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_press,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

  localparam int          LONG_CYCLES   = ms_to_cycles(CLK_FREQ, LONG_MS);
  localparam int          REPEAT_CYCLES = ms_to_cycles(CLK_FREQ, REPEAT_MS);
  localparam int          CNT_MAX       = max_int(LONG_CYCLES, REPEAT_CYCLES);
  localparam int unsigned CNT_W         = $clog2(CNT_MAX + 1);

  // Reject configurations whose thresholds cannot be counted.
  if (LONG_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_cycles
    $error("button_event: LONG_CYCLES and REPEAT_CYCLES must both be >= 2");
  end
  if ((CLK_FREQ % 1000) != 0) begin : g_bad_freq
    $error("button_event: CLK_FREQ must be a multiple of 1000");
  end

  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, release_q, short_q, long_q, repeat_q, held_q;
  logic             press_d, release_d, short_d, long_d, repeat_d, held_d;

  logic [CNT_W-1:0] cnt_inc_c;
  logic             at_long_c;
  logic             at_repeat_c;

  assign cnt_inc_c   = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + CNT_W'(1);
  assign at_long_c   = (cnt_q == CNT_W'(LONG_CYCLES - 1));
  assign at_repeat_c = (cnt_q == CNT_W'(REPEAT_CYCLES - 1));

  // State, counter and all outputs registered together; reset aborts any hold silently.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= WAIT_LOW;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      short_q   <= short_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  // Next state and counter; the counter clears on every state change and on each repeat.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      WAIT_LOW: begin
        if (!btn_level) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      IDLE: begin
        if (btn_level) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end
      end
      PRESSED: begin
        if (!btn_level) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (at_long_c) begin
          state_d = LONG_HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc_c;
        end
      end
      LONG_HELD: begin
        if (!btn_level) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (at_repeat_c) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc_c;
        end
      end
      default: begin
        state_d = WAIT_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Event decode; a release seen on a threshold or repeat cycle takes priority.
  always_comb begin
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        press_d = btn_level;
      end
      PRESSED: begin
        if (!btn_level) begin
          release_d = 1'b1;
          short_d   = 1'b1;
        end else begin
          long_d = at_long_c;
        end
      end
      LONG_HELD: begin
        if (!btn_level) begin
          release_d = 1'b1;
        end else begin
          repeat_d = REPEAT_EN && at_repeat_c;
        end
      end
      default: begin
        press_d = 1'b0;
      end
    endcase
    held_d = (state_d == PRESSED) || (state_d == LONG_HELD);
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign short_press   = short_q;
  assign long_press    = long_q;
  assign repeat_pulse  = repeat_q;
  assign held          = held_q;

endmodule

// File: tb/tb_button_event.sv
// Scoreboard bench for button_event: two instances (repeat enabled / disabled) share stimulus.
module tb_button_event;

  localparam int LONG = 20;
  localparam int REP  = 5;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_level = 1'b0;
  logic [4:0] ev0, ev1;   // {press, release, short, long, repeat}
  logic       held0, held1;

  button_event #(.CLK_FREQ(1000), .LONG_MS(LONG), .REPEAT_MS(REP), .REPEAT_EN(1'b1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .btn_level(btn_level),
    .press_pulse(ev0[4]), .release_pulse(ev0[3]), .short_press(ev0[2]),
    .long_press(ev0[1]), .repeat_pulse(ev0[0]), .held(held0)
  );

  button_event #(.CLK_FREQ(1000), .LONG_MS(LONG), .REPEAT_MS(REP), .REPEAT_EN(1'b0)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .btn_level(btn_level),
    .press_pulse(ev1[4]), .release_pulse(ev1[3]), .short_press(ev1[2]),
    .long_press(ev1[1]), .repeat_pulse(ev1[0]), .held(held1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [4:0] ev;
  } exp_t;

  exp_t evq0[$];
  exp_t evq1[$];
  logic hq0[$];
  logic hq1[$];

  int checks   = 0;
  int failures = 0;
  bit started  = 0;

  // Reference model state: armed after a low since reset, press age in cycles.
  bit m_armed[2];
  bit m_press[2];
  bit m_long[2];
  int m_t[2];

  task automatic model_step(input int id, input logic b, input logic r, input bit en,
                            output logic [4:0] ev, output logic h);
    ev = 5'b0;
    h  = 1'b0;
    if (!r) begin
      m_armed[id] = 0;
      m_press[id] = 0;
      m_long[id]  = 0;
    end else if (!m_armed[id]) begin
      if (!b) m_armed[id] = 1;
    end else if (!m_press[id]) begin
      if (b) begin
        ev[4]       = 1'b1;
        m_press[id] = 1;
        m_long[id]  = 0;
        m_t[id]     = 0;
        h           = 1'b1;
      end
    end else begin
      m_t[id] = m_t[id] + 1;
      if (!b) begin
        ev[3]       = 1'b1;
        ev[2]       = !m_long[id];
        m_press[id] = 0;
      end else begin
        h = 1'b1;
        if (m_t[id] == LONG) begin
          ev[1]      = 1'b1;
          m_long[id] = 1;
        end else if (m_long[id] && ((m_t[id] - LONG) % REP == 0) && en) begin
          ev[0] = 1'b1;
        end
      end
    end
  endtask

  // Apply one cycle of stimulus and record what each instance must show after the next edge.
  task automatic drive(input logic b, input logic r);
    logic [4:0] e;
    logic       h;
    exp_t       x;
    @(negedge clk);
    btn_level = b;
    reset_n   = r;
    model_step(0, b, r, 1'b1, e, h);
    x.cyc = cyc + 1;
    x.ev  = e;
    if (e != 5'b0) evq0.push_back(x);
    hq0.push_back(h);
    model_step(1, b, r, 1'b0, e, h);
    x.ev = e;
    if (e != 5'b0) evq1.push_back(x);
    hq1.push_back(h);
    started = 1;
  endtask

  task automatic drive_n(input logic b, input logic r, input int n);
    for (int i = 0; i < n; i++) drive(b, r);
  endtask

  task automatic check_dut(input int id, input logic [4:0] ev, input logic h);
    logic eh;
    bit   have_ev;
    exp_t e;
    bit   have_h;
    have_h = (id == 0) ? (hq0.size() != 0) : (hq1.size() != 0);
    checks++;
    if (!have_h) begin
      failures++;
      $display("FAIL held_queue dut%0d cyc=%0d no expectation queued", id, cyc);
    end else begin
      eh = (id == 0) ? hq0.pop_front() : hq1.pop_front();
      if (h !== eh) begin
        failures++;
        $display("FAIL held dut%0d cyc=%0d got=%b exp=%b", id, cyc, h, eh);
      end
    end
    have_ev = (id == 0) ? (evq0.size() != 0) : (evq1.size() != 0);
    if (have_ev) e = (id == 0) ? evq0[0] : evq1[0];
    if (ev !== 5'b0) begin
      checks++;
      if (!have_ev) begin
        failures++;
        $display("FAIL unexpected_event dut%0d cyc=%0d got=%b exp=none", id, cyc, ev);
      end else begin
        if (id == 0) void'(evq0.pop_front()); else void'(evq1.pop_front());
        if (e.cyc != cyc || e.ev !== ev) begin
          failures++;
          $display("FAIL event dut%0d cyc=%0d got=%b exp=%b@%0d", id, cyc, ev, e.ev, e.cyc);
        end
      end
    end else if (have_ev && e.cyc <= cyc) begin
      checks++;
      failures++;
      if (id == 0) void'(evq0.pop_front()); else void'(evq1.pop_front());
      $display("FAIL missing_event dut%0d cyc=%0d got=00000 exp=%b@%0d", id, cyc, e.ev, e.cyc);
    end
  endtask

  // Monitor: compare every cycle, away from the active edge.
  initial begin
    wait (started);
    forever begin
      @(posedge clk);
      #1;
      check_dut(0, ev0, held0);
      check_dut(1, ev1, held1);
    end
  end

  // Mid-cycle reset must clear every output without waiting for a clock edge.
  task automatic abort_check();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({ev0, held0, ev1, held1} !== 12'b0) begin
      failures++;
      $display("FAIL async_reset got=%b exp=%b", {ev0, held0, ev1, held1}, 12'b0);
    end
  endtask

  initial begin
    int hi;
    int lo;
    // Button held through reset: no events until a low is seen, then a normal press.
    drive_n(1'b1, 1'b0, 3);
    drive_n(1'b1, 1'b1, 30);
    drive_n(1'b0, 1'b1, 3);
    drive_n(1'b1, 1'b1, 3);
    drive_n(1'b0, 1'b1, 3);
    // Short press of 10 cycles.
    drive_n(1'b1, 1'b1, 10);
    drive_n(1'b0, 1'b1, 3);
    // Long hold: press edge plus 32 more high cycles.
    drive_n(1'b1, 1'b1, 33);
    drive_n(1'b0, 1'b1, 3);
    // Release sampled exactly on the long threshold edge.
    drive_n(1'b1, 1'b1, 20);
    drive_n(1'b0, 1'b1, 3);
    // Release one cycle past the threshold, and a release on a repeat edge.
    drive_n(1'b1, 1'b1, 21);
    drive_n(1'b0, 1'b1, 2);
    drive_n(1'b1, 1'b1, 25);
    drive_n(1'b0, 1'b1, 2);
    // 40-cycle hold.
    drive_n(1'b1, 1'b1, 41);
    drive_n(1'b0, 1'b1, 3);
    // Reset in the middle of a hold, then button still high after reset.
    drive_n(1'b1, 1'b1, 13);
    abort_check();
    drive_n(1'b1, 1'b0, 2);
    drive_n(1'b1, 1'b1, 6);
    drive_n(1'b0, 1'b1, 1);
    drive_n(1'b1, 1'b1, 4);
    drive_n(1'b0, 1'b1, 3);
    // Randomized holds, biased toward the long threshold, with occasional resets.
    for (int k = 0; k < 120; k++) begin
      if ($urandom_range(0, 19) == 0) drive_n(1'($urandom_range(0, 1)), 1'b0, 2);
      if ($urandom_range(0, 3) == 0) hi = 19 + $urandom_range(0, 2);
      else hi = $urandom_range(1, 45);
      lo = $urandom_range(1, 6);
      drive_n(1'b1, 1'b1, hi);
      drive_n(1'b0, 1'b1, lo);
    end
    drive_n(1'b0, 1'b1, 5);
    @(posedge clk);
    #2;
    while (evq0.size() != 0) begin
      exp_t e;
      e = evq0.pop_front();
      checks++;
      failures++;
      $display("FAIL leftover dut0 got=none exp=%b@%0d", e.ev, e.cyc);
    end
    while (evq1.size() != 0) begin
      exp_t e;
      e = evq1.pop_front();
      checks++;
      failures++;
      $display("FAIL leftover dut1 got=none exp=%b@%0d", e.ev, e.cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
